// File: rtl/iq_pkg.sv
// Shared definitions for the issue queue: entry layout, opcode field position, branch decode.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package iq_pkg;

    // Opcode lives in the low byte of the instruction word (entry bits 39:32)
    localparam int OPC_LSB = 32;
    localparam int OPC_MSB = 39;
    localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

    // Opcodes with bits [5:4] == 2'b11 are control flow; plain jumps are never speculated past
    localparam logic [OPC_W-1:0] OPC_BR_MASK = 8'h30;
    localparam logic [OPC_W-1:0] OP_JMP      = 8'h30;

    typedef struct packed {
        logic        taken;
        logic [24:0] taken_addr;
        logic [5:0]  id;
        logic [31:0] inst;
        logic [31:0] pc;
    } iq_entry_t;

    localparam int IQ_ENTRY_W = $bits(iq_entry_t);

    function automatic logic is_branch(input logic [OPC_W-1:0] opc);
        return ((opc & OPC_BR_MASK) == OPC_BR_MASK) && (opc != OP_JMP);
    endfunction

endpackage

// File: rtl/iq_spec_scan.sv
// Speculation mask: an ordered slot is speculative once any older allocated branch precedes it.
// Latency: purely combinational.
// Backpressure: not applicable.
module iq_spec_scan
    import iq_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic [DEPTH-1:0]       ord_alloc,
    input  logic [DEPTH*OPC_W-1:0] ord_opc,
    output logic [DEPTH-1:0]       spec
);

    logic acc;

    // Prefix-OR of "allocated branch" walking from oldest to youngest
    always_comb begin
        spec = '0;
        acc  = 1'b0;
        for (int j = 1; j < DEPTH; j++) begin
            acc     = acc | (ord_alloc[j-1] & is_branch(ord_opc[(j-1)*OPC_W +: OPC_W]));
            spec[j] = acc;
        end
    end

endmodule

// File: rtl/issue_queue_param.sv
// Circular issue queue: in-order alloc, out-of-order issue, in-order retire, branch flush.
// Latency: outputs combinational from state; pushes visible next cycle (same cycle with IQ_BYPASS_EN).
// Backpressure: lanes beyond the advertised free count are dropped; callers must watch free.
module issue_queue_param
    import iq_pkg::*;
#(
    parameter  int DEPTH   = 8,
    parameter  int ENTRY_W = 96,
    parameter  int PUSH_W  = 2,
    parameter  int POP_W   = 2,
    parameter  int RET_W   = 2,
    localparam int IDX_W   = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [PUSH_W-1:0]          push,
    input  logic [PUSH_W*ENTRY_W-1:0]  push_data,
    output logic [IDX_W:0]             free,
    input  logic [POP_W-1:0]           pop,
    input  logic [POP_W*IDX_W-1:0]     pop_key,
    input  logic [RET_W-1:0]           retire,
    input  logic                       flush,
    input  logic [IDX_W-1:0]           flush_idx,
    output logic [DEPTH*ENTRY_W-1:0]   slot_data,
    output logic [DEPTH*IDX_W-1:0]     slot_index,
    output logic [DEPTH-1:0]           slot_vld,
    output logic [DEPTH-1:0]           spec,
    output logic [RET_W*IDX_W-1:0]     oldest
);

    localparam int CW = IDX_W + 1;

    logic [ENTRY_W-1:0]     mem [DEPTH];
    logic [DEPTH-1:0]       alloc_q, issued_q;
    logic [IDX_W-1:0]       rd_ptr, wr_ptr;
    logic [CW-1:0]          count;

    logic [DEPTH-1:0]       alloc_n, issued_n;
    logic [IDX_W-1:0]       rd_n, wr_n;
    logic [CW-1:0]          count_n;

    logic [CW-1:0]          push_cnt, ret_cnt, accepted, ret_n;
    logic [IDX_W-1:0]       order [DEPTH];
    logic [ENTRY_W-1:0]     view  [DEPTH];
    logic [PUSH_W-1:0]      we;
    logic [DEPTH-1:0]       ord_alloc;
    logic [DEPTH*OPC_W-1:0] ord_opc;
    logic [IDX_W-1:0]       key, pos_f;
    logic                   ret_bad;
`ifdef IQ_BYPASS_EN
    logic [DEPTH-1:0]       fwd;
`endif

    assign free = CW'(DEPTH) - count;

    // Lane counts; pushes are limited by the pre-retire free count, retires by occupancy
    always_comb begin
        push_cnt = '0;
        ret_cnt  = '0;
        for (int k = 0; k < PUSH_W; k++) push_cnt = push_cnt + CW'(push[k]);
        for (int k = 0; k < RET_W; k++)  ret_cnt  = ret_cnt + CW'(retire[k]);
        accepted = (push_cnt > free)  ? free  : push_cnt;
        ret_n    = (ret_cnt  > count) ? count : ret_cnt;
    end

    // Ordered slot j maps to physical rd_ptr + j
    always_comb begin
        for (int j = 0; j < DEPTH; j++) order[j] = rd_ptr + IDX_W'(j);
    end

`ifdef IQ_BYPASS_EN
    // Ordered slots being filled by this cycle's accepted push lanes
    always_comb begin
        fwd = '0;
        for (int j = 0; j < DEPTH; j++)
            fwd[j] = !flush && (CW'(j) >= count) && (CW'(j) < count + accepted);
    end
`endif

    // Oldest-first view of the queue; empty slots read as zero
    always_comb begin
        slot_data  = '0;
        slot_index = '0;
        slot_vld   = '0;
        ord_alloc  = '0;
        ord_opc    = '0;
        for (int j = 0; j < DEPTH; j++) begin
            view[j]      = alloc_q[order[j]] ? mem[order[j]] : '0;
            ord_alloc[j] = alloc_q[order[j]];
            slot_vld[j]  = alloc_q[order[j]] & ~issued_q[order[j]];
`ifdef IQ_BYPASS_EN
            if (fwd[j]) begin
                view[j]      = push_data[(j - int'(count))*ENTRY_W +: ENTRY_W];
                ord_alloc[j] = 1'b1;
                slot_vld[j]  = 1'b1;
            end
`endif
            slot_data[j*ENTRY_W +: ENTRY_W] = view[j];
            slot_index[j*IDX_W +: IDX_W]    = order[j];
            ord_opc[j*OPC_W +: OPC_W]       = view[j][OPC_MSB:OPC_LSB];
        end
    end

    // Physical indices of the retire window
    always_comb begin
        oldest = '0;
        for (int k = 0; k < RET_W; k++) oldest[k*IDX_W +: IDX_W] = order[k];
    end

    iq_spec_scan #(
        .DEPTH (DEPTH)
    ) u_spec (
        .ord_alloc (ord_alloc),
        .ord_opc   (ord_opc),
        .spec      (spec)
    );

    // Next state: push/pop unless flushing, flush trims younger entries, retire clears last so it beats pop
    always_comb begin
        alloc_n  = alloc_q;
        issued_n = issued_q;
        rd_n     = rd_ptr + ret_n[IDX_W-1:0];
        wr_n     = wr_ptr;
        count_n  = count;
        we       = '0;
        key      = '0;
        pos_f    = flush_idx - rd_ptr;
        if (!flush) begin
            for (int k = 0; k < PUSH_W; k++) begin
                if (CW'(k) < accepted) begin
                    we[k]                             = 1'b1;
                    alloc_n[wr_ptr + IDX_W'(k)]  = 1'b1;
                    issued_n[wr_ptr + IDX_W'(k)] = 1'b0;
                end
            end
            for (int l = 0; l < POP_W; l++) begin
                if (pop[l]) begin
                    key = pop_key[l*IDX_W +: IDX_W];
                    if (alloc_q[order[key]]) issued_n[order[key]] = 1'b1;
`ifdef IQ_BYPASS_EN
                    else if (fwd[key]) issued_n[order[key]] = 1'b1;
`endif
                end
            end
            wr_n    = wr_ptr + accepted[IDX_W-1:0];
            count_n = count + accepted - ret_n;
        end else begin
            for (int j = 0; j < DEPTH; j++) begin
                if (IDX_W'(j) > pos_f) begin
                    alloc_n[order[j]]  = 1'b0;
                    issued_n[order[j]] = 1'b0;
                end
            end
            // Branch retiring in the flush cycle leaves nothing behind it
            if ({1'b0, pos_f} < ret_n) begin
                count_n = '0;
                wr_n    = rd_n;
            end else begin
                count_n = {1'b0, pos_f} + CW'(1) - ret_n;
                wr_n    = flush_idx + IDX_W'(1);
            end
        end
        for (int k = 0; k < RET_W; k++) begin
            if (CW'(k) < ret_n) begin
                alloc_n[order[k]]  = 1'b0;
                issued_n[order[k]] = 1'b0;
            end
        end
    end

    // Control state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alloc_q  <= '0;
            issued_q <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            alloc_q  <= alloc_n;
            issued_q <= issued_n;
            rd_ptr   <= rd_n;
            wr_ptr   <= wr_n;
            count    <= count_n;
        end
    end

    // Payload RAM; contents are masked by alloc so no reset is needed
    always_ff @(posedge clk) begin
        for (int k = 0; k < PUSH_W; k++) begin
            if (we[k]) mem[wr_ptr + IDX_W'(k)] <= push_data[k*ENTRY_W +: ENTRY_W];
        end
    end

    // An entry may only retire after it has issued
    always_comb begin
        ret_bad = 1'b0;
        for (int k = 0; k < RET_W; k++) begin
            if ((CW'(k) < ret_n) && !issued_q[order[k]]) ret_bad = 1'b1;
        end
    end

    assert property (@(posedge clk) disable iff (!reset_n) !ret_bad);

endmodule

// File: tb/tb_issue_queue_param.sv
module tb_issue_queue_param;
    import iq_pkg::*;

    localparam int DEPTH = 8;
    localparam int EW    = 96;
    localparam int IW    = 3;
    localparam logic [7:0] N = 8'h01;
    localparam logic [7:0] B = 8'h33;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic [1:0]            push;
    logic [2*EW-1:0]       push_data;
    logic [IW:0]           free;
    logic [1:0]            pop;
    logic [2*IW-1:0]       pop_key;
    logic [1:0]            retire;
    logic                  flush;
    logic [IW-1:0]         flush_idx;
    logic [DEPTH*EW-1:0]   slot_data;
    logic [DEPTH*IW-1:0]   slot_index;
    logic [DEPTH-1:0]      slot_vld;
    logic [DEPTH-1:0]      spec;
    logic [2*IW-1:0]       oldest;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] push;
        logic [7:0] tag0, opc0, tag1, opc1;
        logic [1:0] pop;
        logic [2:0] key0, key1;
        logic [1:0] ret;
        logic       flush;
        logic [2:0] fidx;
        logic [3:0] e_free;
        logic [7:0] e_vld, e_spec;
        logic [2:0] e_rd;
        int         chk_j;
        logic [7:0] e_tag;
    } vec_t;

    vec_t vt [18];

    issue_queue_param dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push),
        .push_data  (push_data),
        .free       (free),
        .pop        (pop),
        .pop_key    (pop_key),
        .retire     (retire),
        .flush      (flush),
        .flush_idx  (flush_idx),
        .slot_data  (slot_data),
        .slot_index (slot_index),
        .slot_vld   (slot_vld),
        .spec       (spec),
        .oldest     (oldest)
    );

    always #5 clk = ~clk;

    function automatic logic [EW-1:0] mk(input logic [7:0] tag, input logic [7:0] opc);
        iq_entry_t e;
        e      = '0;
        e.pc   = {24'h0, tag};
        e.id   = tag[5:0];
        e.inst = {24'h0, opc};
        return e;
    endfunction

    function automatic vec_t mkv(input logic [1:0] p, input logic [7:0] t0, o0, t1, o1,
                                 input logic [1:0] pp, input logic [2:0] k0, k1,
                                 input logic [1:0] r, input logic f, input logic [2:0] fi,
                                 input logic [3:0] ef, input logic [7:0] ev, es,
                                 input logic [2:0] erd, input int cj, input logic [7:0] et);
        vec_t v;
        v.push = p; v.tag0 = t0; v.opc0 = o0; v.tag1 = t1; v.opc1 = o1;
        v.pop = pp; v.key0 = k0; v.key1 = k1; v.ret = r; v.flush = f; v.fidx = fi;
        v.e_free = ef; v.e_vld = ev; v.e_spec = es; v.e_rd = erd; v.chk_j = cj; v.e_tag = et;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        push = '0; push_data = '0; pop = '0; pop_key = '0;
        retire = '0; flush = 1'b0; flush_idx = '0;
    endtask

    task automatic apply(input vec_t v);
        push      = v.push;
        push_data = {mk(v.tag1, v.opc1), mk(v.tag0, v.opc0)};
        pop       = v.pop;
        pop_key   = {v.key1, v.key0};
        retire    = v.ret;
        flush     = v.flush;
        flush_idx = v.fidx;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        idle();
    endtask

    task automatic check_state(input string lbl, input logic [3:0] ef, input logic [7:0] ev,
                               input logic [7:0] es, input logic [2:0] erd,
                               input int cj, input logic [7:0] etag);
        logic [DEPTH*IW-1:0] exp_idx;
        for (int j = 0; j < DEPTH; j++) exp_idx[j*IW +: IW] = erd + 3'(j);
        chk({lbl, " free"},   32'(free),       32'(ef));
        chk({lbl, " vld"},    32'(slot_vld),   32'(ev));
        chk({lbl, " spec"},   32'(spec),       32'(es));
        chk({lbl, " index"},  32'(slot_index), 32'(exp_idx));
        chk({lbl, " oldest"}, 32'(oldest),     32'(exp_idx[2*IW-1:0]));
        chk({lbl, " tag"},    32'(slot_data[cj*EW +: 8]), 32'(etag));
    endtask

    initial begin
        reset_n = 1'b0;
        idle();

        // Fill, drop, issue, retire, wrap, branch flush
        vt[0]  = mkv(2'b11, 8'h10, N, 8'h11, N, 2'b00, 0, 0, 2'b00, 0, 0, 6, 8'h03, 8'h00, 0, 1, 8'h11);
        vt[1]  = mkv(2'b11, 8'h12, N, 8'h13, N, 2'b00, 0, 0, 2'b00, 0, 0, 4, 8'h0F, 8'h00, 0, 3, 8'h13);
        vt[2]  = mkv(2'b11, 8'h14, N, 8'h15, N, 2'b00, 0, 0, 2'b00, 0, 0, 2, 8'h3F, 8'h00, 0, 5, 8'h15);
        vt[3]  = mkv(2'b11, 8'h16, N, 8'h17, N, 2'b00, 0, 0, 2'b00, 0, 0, 0, 8'hFF, 8'h00, 0, 7, 8'h17);
        vt[4]  = mkv(2'b11, 8'h18, N, 8'h19, N, 2'b00, 0, 0, 2'b00, 0, 0, 0, 8'hFF, 8'h00, 0, 0, 8'h10);
        vt[5]  = mkv(2'b00, 8'h00, N, 8'h00, N, 2'b11, 3, 5, 2'b00, 0, 0, 0, 8'hD7, 8'h00, 0, 3, 8'h13);
        vt[6]  = mkv(2'b00, 8'h00, N, 8'h00, N, 2'b11, 0, 1, 2'b00, 0, 0, 0, 8'hD4, 8'h00, 0, 0, 8'h10);
        vt[7]  = mkv(2'b00, 8'h00, N, 8'h00, N, 2'b00, 0, 0, 2'b11, 0, 0, 2, 8'h35, 8'h00, 2, 7, 8'h00);
        vt[8]  = mkv(2'b00, 8'h00, N, 8'h00, N, 2'b11, 0, 2, 2'b00, 0, 0, 2, 8'h30, 8'h00, 2, 0, 8'h12);
        vt[9]  = mkv(2'b00, 8'h00, N, 8'h00, N, 2'b00, 0, 0, 2'b11, 0, 0, 4, 8'h0C, 8'h00, 4, 0, 8'h14);
        vt[10] = mkv(2'b00, 8'h00, N, 8'h00, N, 2'b00, 0, 0, 2'b00, 1, 5, 6, 8'h00, 8'h00, 4, 2, 8'h00);
        vt[11] = mkv(2'b00, 8'h00, N, 8'h00, N, 2'b00, 0, 0, 2'b11, 0, 0, 8, 8'h00, 8'h00, 6, 0, 8'h00);
        vt[12] = mkv(2'b11, 8'h20, N, 8'h21, N, 2'b00, 0, 0, 2'b00, 0, 0, 6, 8'h03, 8'h00, 6, 1, 8'h21);
        vt[13] = mkv(2'b11, 8'h22, N, 8'h23, N, 2'b00, 0, 0, 2'b00, 0, 0, 4, 8'h0F, 8'h00, 6, 2, 8'h22);
        vt[14] = mkv(2'b11, 8'h24, B, 8'h25, N, 2'b00, 0, 0, 2'b00, 0, 0, 2, 8'h3F, 8'hE0, 6, 4, 8'h24);
        vt[15] = mkv(2'b11, 8'h26, N, 8'h27, N, 2'b00, 0, 0, 2'b00, 0, 0, 0, 8'hFF, 8'hE0, 6, 7, 8'h27);
        vt[16] = mkv(2'b11, 8'h28, N, 8'h29, N, 2'b01, 0, 0, 2'b00, 1, 2, 3, 8'h1F, 8'hE0, 6, 5, 8'h00);
        vt[17] = mkv(2'b11, 8'h2A, N, 8'h2B, N, 2'b00, 0, 0, 2'b00, 0, 0, 1, 8'h7F, 8'hE0, 6, 5, 8'h2A);

        @(negedge clk);
        chk("reset free", 32'(free), 32'd8);
        chk("reset vld", 32'(slot_vld), 32'd0);
        chk("reset spec", 32'(spec), 32'd0);
        chk("reset data", {31'b0, |slot_data}, 32'd0);
        chk("reset oldest", 32'(oldest), 32'h08);
        reset_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            apply(vt[i]);
            step();
            check_state($sformatf("v%0d", i), vt[i].e_free, vt[i].e_vld, vt[i].e_spec,
                        vt[i].e_rd, vt[i].chk_j, vt[i].e_tag);
        end

        // Issue the oldest, then flush at the branch while retiring it, pushing and popping
        pop = 2'b01; pop_key = '0;
        step();
        check_state("h1", 1, 8'h7E, 8'hE0, 6, 0, 8'h20);

        flush = 1'b1; flush_idx = 3'd2; retire = 2'b01; push = 2'b11;
        push_data = {mk(8'h31, N), mk(8'h30, N)};
        pop = 2'b11; pop_key = {3'd2, 3'd1};
        step();
        check_state("h2", 4, 8'h0F, 8'hF0, 7, 4, 8'h00);

        // Flush whose target retires in the same cycle empties the queue
        pop = 2'b01; pop_key = '0;
        step();
        check_state("h3", 4, 8'h0E, 8'hF0, 7, 0, 8'h21);

        flush = 1'b1; flush_idx = 3'd7; retire = 2'b01;
        step();
        check_state("h4", 8, 8'h00, 8'h00, 0, 0, 8'h00);

        push = 2'b01; push_data = {mk(8'h00, N), mk(8'h40, N)};
        step();
        check_state("h5", 7, 8'h01, 8'h00, 0, 0, 8'h40);

        // Asynchronous reset in the middle of a fill
        push = 2'b11; push_data = {mk(8'h51, B), mk(8'h50, B)};
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async rst free", 32'(free), 32'd8);
        chk("async rst vld", 32'(slot_vld), 32'd0);
        chk("async rst spec", 32'(spec), 32'd0);
        @(negedge clk);
        idle();
        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_state("rst2", 8, 8'h00, 8'h00, 0, 0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
